// File: rtl/shared_ocm_block_reader_if.sv
// Command, shared-memory port and stream signals
// of the shared OCM block reader.
interface shared_ocm_block_reader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [ADDR_W-1:0]   cmd_base;
  logic [ADDR_W:0]     cmd_len;
  logic [ADDR_W-1:0]   cmd_ack_addr;
  logic [ADDR_W-1:0]   ocm_address;
  logic                ocm_chipselect;
  logic                ocm_write;
  logic [DATA_W-1:0]   ocm_writedata;
  logic [DATA_W/8-1:0] ocm_byteenable;
  logic                ocm_clken;
  logic [DATA_W-1:0]   ocm_readdata;
  logic [DATA_W-1:0]   st_data;
  logic                st_valid;
  logic                st_ready;
  logic                st_sop;
  logic                st_eop;
  logic                busy;
  logic                done;

  modport master (
    input  cmd_valid, cmd_base, cmd_len,
    input  cmd_ack_addr, ocm_readdata, st_ready,
    output cmd_ready, ocm_address, ocm_chipselect,
    output ocm_write, ocm_writedata, ocm_byteenable,
    output ocm_clken, st_data, st_valid, st_sop,
    output st_eop, busy, done
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_len,
    output cmd_ack_addr, ocm_readdata, st_ready,
    input  cmd_ready, ocm_address, ocm_chipselect,
    input  ocm_write, ocm_writedata, ocm_byteenable,
    input  ocm_clken, st_data, st_valid, st_sop,
    input  st_eop, busy, done
  );
endinterface

// File: rtl/shared_ocm_block_reader.sv
// Streams a block from the shared OCM onto an ST source,
// then writes a completion word back to the mailbox.
module shared_ocm_block_reader #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter bit ACK_EN     = 1'b1
) (
  input logic                       clk,
  input logic                       reset_n,
  shared_ocm_block_reader_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = ADDR_W + 1;
  localparam logic [LW-1:0] MAXLEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LW-1:0] ONE = LW'(1);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] ACK_FLAG =
    DATA_W'(1) << (DATA_W-1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DRAIN, S_ACK, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [ADDR_W-1:0] r_base, r_ack_addr;
  logic [LW-1:0]     r_len, r_issue, r_beat, w_len;
  logic              r_inflight;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wr, r_rd;
  logic [PW:0]       r_count;
  logic w_accept, w_issue, w_push, w_pop, w_valid;
  logic w_last_issue, w_last_beat, w_ack;

  assign w_len = (bus.cmd_len > MAXLEN) ? MAXLEN : bus.cmd_len;
  assign w_accept = bus.cmd_valid && (r_state == S_IDLE);
  assign w_valid = (r_count != '0);
  assign w_pop = w_valid && bus.st_ready;
  assign w_push = r_inflight;
  assign w_ack = (r_state == S_ACK);
  // Credits: buffered words plus the one read still in flight.
  assign w_issue = (r_state == S_READ) &&
    ((r_count + {{PW{1'b0}}, r_inflight}) < DEPTH_C);
  assign w_last_issue = w_issue && (r_issue == r_len - ONE);
  assign w_last_beat = w_pop && (r_beat == r_len - ONE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) begin
        if (w_len != '0) w_next = S_READ;
        else w_next = ACK_EN ? S_ACK : S_DONE;
      end
      S_READ:  if (w_last_issue) w_next = S_DRAIN;
      S_DRAIN: if (w_last_beat) begin
        w_next = ACK_EN ? S_ACK : S_DONE;
      end
      S_ACK:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Command capture and block progress counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_base     <= '0;
      r_ack_addr <= '0;
      r_len      <= '0;
      r_issue    <= '0;
      r_beat     <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_accept) begin
        r_base     <= bus.cmd_base;
        r_ack_addr <= bus.cmd_ack_addr;
        r_len      <= w_len;
        r_issue    <= '0;
        r_beat     <= '0;
      end
      if (w_issue) r_issue <= r_issue + ONE;
      if (w_pop)   r_beat  <= r_beat + ONE;
      r_inflight <= w_issue;
    end
  end

  // FIFO pointers and occupancy; reset drops buffered data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + (PW+1)'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - (PW+1)'(1);
    end
  end

  // FIFO storage; contents are masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= bus.ocm_readdata;
  end

  assign bus.cmd_ready = reset_n && (r_state == S_IDLE);
  assign bus.ocm_clken = reset_n;
  assign bus.ocm_chipselect = w_issue || w_ack;
  assign bus.ocm_write = w_ack;
  assign bus.ocm_address =
    w_issue ? r_base + r_issue[ADDR_W-1:0] :
    w_ack   ? r_ack_addr : '0;
  assign bus.ocm_writedata =
    w_ack ? (ACK_FLAG | DATA_W'(r_len)) : '0;
  assign bus.ocm_byteenable =
    {(DATA_W/8){bus.ocm_chipselect}};
  assign bus.st_valid = w_valid;
  assign bus.st_data = w_valid ? r_mem[r_rd] : '0;
  assign bus.st_sop = w_valid && (r_beat == '0);
  assign bus.st_eop = w_valid && (r_beat == r_len - ONE);
  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = (r_state == S_DONE);
endmodule

// File: tb/tb_shared_ocm_block_reader.sv
// Scoreboard bench for shared_ocm_block_reader:
// random commands, backpressure, reset and ACK_EN=0.
module tb_shared_ocm_block_reader;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] d;
    logic s;
    logic e;
  } beat_t;

  typedef struct {
    logic [7:0] a;
    logic [31:0] d;
    int c;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  shared_ocm_block_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus0();
  shared_ocm_block_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus1();

  shared_ocm_block_reader #(
    .ADDR_W(AW), .DATA_W(DW),
    .FIFO_DEPTH(DEPTH), .ACK_EN(1'b1)
  ) u0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

  shared_ocm_block_reader #(
    .ADDR_W(AW), .DATA_W(DW),
    .FIFO_DEPTH(DEPTH), .ACK_EN(1'b0)
  ) u1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  logic [31:0] mem [256];
  int ntests = 0;
  int nfail = 0;
  int cyc = 0;
  int t0 = 0;
  int rd_n = 0;
  int pop_n = 0;
  int beats_seen = 0;
  int done_n = 0;
  int rmode = 0;
  int rph = 0;
  logic stall_p = 1'b0;
  beat_t last_b;
  beat_t q_beat[$];
  wr_t q_wr[$];
  int q_rd[$];
  int q_done[$];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus0.ocm_chipselect && !bus0.ocm_write)
      bus0.ocm_readdata <= mem[bus0.ocm_address];
    if (bus1.ocm_chipselect && !bus1.ocm_write)
      bus1.ocm_readdata <= mem[bus1.ocm_address];
  end

  initial begin
    bus0.st_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rph++;
      case (rmode)
        0: bus0.st_ready = 1'b1;
        1: bus0.st_ready = 1'($urandom_range(0, 1));
        default: begin
          if ((rph % 30) >= 20) bus0.st_ready = 1'b0;
          else bus0.st_ready = ((rph % 4) == 0) || ((rph % 4) == 3);
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      stall_p = 1'b0;
      rd_n = 0;
      pop_n = 0;
    end else begin
      if (bus0.cmd_valid && bus0.cmd_ready) begin
        t0 = cyc;
        rd_n = 0;
        pop_n = 0;
        beats_seen = 0;
      end
      if (bus0.ocm_chipselect)
        chk("byteenable", bus0.ocm_byteenable, 4'hf);
      if (bus0.ocm_chipselect && !bus0.ocm_write) begin
        chk("credit", longint'((rd_n - pop_n) < DEPTH), 1);
        chk("rd expected", longint'(q_rd.size() > 0), 1);
        if (q_rd.size() > 0)
          chk("rd addr", bus0.ocm_address, q_rd.pop_front());
        rd_n++;
      end
      if (bus0.ocm_chipselect && bus0.ocm_write) begin
        chk("wr expected", longint'(q_wr.size() > 0), 1);
        if (q_wr.size() > 0) begin
          wr_t w;
          w = q_wr.pop_front();
          chk("wr addr", bus0.ocm_address, w.a);
          chk("wr data", bus0.ocm_writedata, w.d);
          if (w.c >= 0) chk("wr cycle", cyc - t0, w.c);
        end
      end
      if (stall_p && bus0.st_valid) begin
        chk("stall data", bus0.st_data, last_b.d);
        chk("stall sop", bus0.st_sop, last_b.s);
        chk("stall eop", bus0.st_eop, last_b.e);
      end
      if (bus0.st_valid && bus0.st_ready) begin
        chk("beat expected", longint'(q_beat.size() > 0), 1);
        if (q_beat.size() > 0) begin
          beat_t b;
          b = q_beat.pop_front();
          chk("beat data", bus0.st_data, b.d);
          chk("beat sop", bus0.st_sop, b.s);
          chk("beat eop", bus0.st_eop, b.e);
        end
        pop_n++;
        beats_seen++;
      end
      stall_p = bus0.st_valid && !bus0.st_ready;
      last_b.d = bus0.st_data;
      last_b.s = bus0.st_sop;
      last_b.e = bus0.st_eop;
      if (bus0.done) begin
        chk("done expected", longint'(q_done.size() > 0), 1);
        if (q_done.size() > 0) begin
          int e;
          e = q_done.pop_front();
          if (e >= 0) chk("done cycle", cyc - t0, e);
        end
        done_n++;
      end
    end
  end

  task automatic start_cmd(input logic [7:0] b,
                           input logic [8:0] l,
                           input logic [7:0] a,
                           input int m);
    int len;
    int k;
    len = (l > 9'd256) ? 256 : int'(l);
    rmode = m;
    for (int i = 0; i < len; i++) begin
      beat_t x;
      x.d = 32'h1000_0000 + ((int'(b) + i) % 256);
      x.s = (i == 0);
      x.e = (i == len - 1);
      q_beat.push_back(x);
      q_rd.push_back((int'(b) + i) % 256);
    end
    begin
      wr_t w;
      w.a = a;
      w.d = 32'h8000_0000 | len;
      w.c = (m != 0) ? -1 : (len == 0) ? 1 : len + 3;
      q_wr.push_back(w);
    end
    q_done.push_back((m != 0) ? -1 : (len == 0) ? 2 : len + 4);
    @(posedge clk);
    #1;
    bus0.cmd_valid = 1'b1;
    bus0.cmd_base = b;
    bus0.cmd_len = l;
    bus0.cmd_ack_addr = a;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus0.cmd_ready && k < 100);
    chk("cmd accepted", bus0.cmd_ready, 1);
    @(posedge clk);
    #1;
    bus0.cmd_valid = 1'b0;
    bus0.cmd_base = 8'($urandom);
    bus0.cmd_len = 9'($urandom);
    bus0.cmd_ack_addr = 8'($urandom);
  endtask

  task automatic wait_done();
    int dn;
    int k;
    dn = done_n;
    k = 0;
    while (done_n == dn && k < 3000) begin
      @(posedge clk);
      k++;
    end
    chk("cmd completes", longint'(done_n != dn), 1);
  endtask

  task automatic run_cmd(input logic [7:0] b,
                         input logic [8:0] l,
                         input logic [7:0] a,
                         input int m);
    start_cmd(b, l, a, m);
    wait_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " cmd_ready"}, bus0.cmd_ready, 0);
    chk({tag, " clken"}, bus0.ocm_clken, 0);
    chk({tag, " chipselect"}, bus0.ocm_chipselect, 0);
    chk({tag, " write"}, bus0.ocm_write, 0);
    chk({tag, " address"}, bus0.ocm_address, 0);
    chk({tag, " writedata"}, bus0.ocm_writedata, 0);
    chk({tag, " byteenable"}, bus0.ocm_byteenable, 0);
    chk({tag, " st_valid"}, bus0.st_valid, 0);
    chk({tag, " st_data"}, bus0.st_data, 0);
    chk({tag, " st_sop"}, bus0.st_sop, 0);
    chk({tag, " st_eop"}, bus0.st_eop, 0);
    chk({tag, " busy"}, bus0.busy, 0);
    chk({tag, " done"}, bus0.done, 0);
  endtask

  task automatic run_noack();
    int wr;
    int dn;
    int nb;
    int t;
    wr = 0;
    dn = -1;
    nb = 0;
    bus1.st_ready = 1'b1;
    @(posedge clk);
    #1;
    bus1.cmd_valid = 1'b1;
    bus1.cmd_base = 8'h40;
    bus1.cmd_len = 9'd3;
    bus1.cmd_ack_addr = 8'h20;
    @(negedge clk);
    chk("noack cmd_ready", bus1.cmd_ready, 1);
    t = cyc;
    @(posedge clk);
    #1;
    bus1.cmd_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus1.ocm_chipselect && bus1.ocm_write) wr++;
      if (bus1.st_valid && bus1.st_ready) begin
        chk("noack beat", bus1.st_data, 32'h1000_0040 + nb);
        nb++;
      end
      if (bus1.done) dn = cyc - t;
    end
    chk("noack writes", wr, 0);
    chk("noack done cycle", dn, 6);
    chk("noack beats", nb, 3);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus0.cmd_valid = 1'b0;
    bus0.cmd_base = '0;
    bus0.cmd_len = '0;
    bus0.cmd_ack_addr = '0;
    bus1.cmd_valid = 1'b0;
    bus1.cmd_base = '0;
    bus1.cmd_len = '0;
    bus1.cmd_ack_addr = '0;
    bus1.st_ready = 1'b1;
    #12;
    check_reset_outputs("in reset");
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    chk("post-reset cmd_ready", bus0.cmd_ready, 1);
    chk("post-reset clken", bus0.ocm_clken, 1);
    chk("post-reset busy", bus0.busy, 0);

    run_cmd(8'h10, 9'd4, 8'h80, 0);
    run_cmd(8'hFE, 9'd4, 8'h81, 0);
    run_cmd(8'h30, 9'd16, 8'h82, 2);
    run_cmd(8'h55, 9'd0, 8'h83, 0);
    run_cmd(8'h66, 9'd1, 8'h84, 0);
    run_cmd(8'h00, 9'd300, 8'h85, 1);

    start_cmd(8'h20, 9'd16, 8'h86, 0);
    k = 0;
    while (beats_seen < 5 && k < 200) begin
      @(posedge clk);
      k++;
    end
    chk("reach beat 5", beats_seen, 5);
    #1;
    reset_n = 1'b0;
    q_beat.delete();
    q_wr.delete();
    q_rd.delete();
    q_done.delete();
    #1;
    check_reset_outputs("mid reset");
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (30) @(posedge clk);
    chk("no late done", done_n, 6);
    run_cmd(8'h50, 9'd16, 8'h87, 0);

    run_noack();

    for (int n = 0; n < 8; n++) begin
      int r;
      logic [8:0] l;
      r = $urandom_range(0, 9);
      if (r == 0) l = 9'd0;
      else if (r == 1) l = 9'd1;
      else if (r == 2) l = 9'd300;
      else l = 9'($urandom_range(2, 24));
      run_cmd(8'($urandom), l, 8'($urandom),
              $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    chk("beats left", q_beat.size(), 0);
    chk("reads left", q_rd.size(), 0);
    chk("writes left", q_wr.size(), 0);
    chk("dones left", q_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
